// File: rtl/jt6295_pkg.sv
// Shared types and constants for the jt6295 ROM read cache.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
//
// ROM_AW/MEM_AW are the byte-address and word-address widths of the two ports.
// LINE_AW is the width of a 4-byte line base (byte address without the offset).
package jt6295_pkg;

    localparam int ROM_AW  = 18;
    localparam int MEM_AW  = 17;
    localparam int LINE_AW = ROM_AW - 2;

    // Line-fill sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ0 = 2'd1,
        ST_GAP  = 2'd2,
        ST_REQ1 = 2'd3
    } fill_state_t;

    // Number of line-index bits for a cache of 'lines' entries.
    function automatic int index_bits(input int lines);
        return $clog2(lines);
    endfunction

    // Tag width: everything in the line base that is not the index.
    function automatic int tag_bits(input int lines);
        return LINE_AW - $clog2(lines);
    endfunction

endpackage

// File: rtl/jt6295_romcache_fill.sv
// Two-beat line-fill sequencer: REQ0, one idle GAP cycle, REQ1.
// Latency: mem_cs rises the cycle after start; each beat waits for mem_ok.
// Backpressure: holds mem_cs/mem_addr until mem_ok; accepts start only when idle.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a fill of line 'base' (ignored unless idle)
//   base            line base address (byte address >> 2)
//   mem_ok          read data valid for the current beat
//   mem_cs/mem_addr registered external read request
//   line            base of the line being filled (valid while busy)
//   busy            a fill is in progress
//   wr0/wr1         strobe: mem_data holds word 0 / word 1 of the line
module jt6295_romcache_fill
    import jt6295_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LINE_AW-1:0] base,
    input  logic               mem_ok,
    output logic               mem_cs,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [LINE_AW-1:0] line,
    output logic               busy,
    output logic               wr0,
    output logic               wr1
);

    fill_state_t state;

    // mem_cs and mem_addr are flops so that the request is glitch-free and
    // mem_cs drops asynchronously with reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            mem_cs   <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_REQ0;
                        mem_cs   <= 1'b1;
                        mem_addr <= {base, 1'b0};
                    end
                end
                ST_REQ0: begin
                    if (mem_ok) begin
                        state  <= ST_GAP;
                        mem_cs <= 1'b0;
                    end
                end
                // One dead cycle between beats lets the memory slot see a
                // clean request edge for the second word.
                ST_GAP: begin
                    state       <= ST_REQ1;
                    mem_cs      <= 1'b1;
                    mem_addr[0] <= 1'b1;
                end
                ST_REQ1: begin
                    if (mem_ok) begin
                        state  <= ST_IDLE;
                        mem_cs <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    mem_cs <= 1'b0;
                end
            endcase
        end
    end

    // The line base is carried in the upper request address bits for the
    // whole fill, so no separate base register is needed.
    assign line = mem_addr[MEM_AW-1:1];
    assign busy = (state != ST_IDLE);

    // mem_ok outside the request states never produces a write.
    assign wr0  = (state == ST_REQ0) && mem_ok;
    assign wr1  = (state == ST_REQ1) && mem_ok;

endmodule

// File: rtl/jt6295_romcache.sv
// Direct-mapped 4-byte-line read cache between the jt6295 byte ROM port and a 16-bit memory slot.
// Latency: hit -> rom_ok next cycle; miss -> two-beat fill, zero-wait memory gives rom_ok 6 cycles after detect.
// Backpressure: rom_ok stays low until the byte is available; one outstanding memory request at most.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous invalidate of every line (e.g. ROM bank change)
//   rom_addr     byte address from the ADPCM core
//   rom_data     registered byte for rom_addr, meaningful when rom_ok
//   rom_ok       rom_data belongs to the current rom_addr
//   mem_cs       external read request, held until mem_ok
//   mem_addr     external 16-bit word address
//   mem_data     external read data, low byte = even address
//   mem_ok       one-cycle data-valid pulse for the pending request
module jt6295_romcache
    import jt6295_pkg::*;
#(
    parameter int LINES = 4     // power of two, 2..16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_ok,
    output logic              mem_cs,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    input  logic              mem_ok
);

    localparam int IW = index_bits(LINES);
    localparam int TW = tag_bits(LINES);

    // ------------------------------------------------------------------
    // Storage: flops, small enough that a RAM would not pay off.
    // ------------------------------------------------------------------
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [31:0]      data [LINES];

    // ------------------------------------------------------------------
    // Address split of the incoming read.
    // ------------------------------------------------------------------
    logic [1:0]    rd_off;
    logic [IW-1:0] rd_idx;
    logic [TW-1:0] rd_tag;

    assign rd_off = rom_addr[1:0];
    assign rd_idx = rom_addr[2 +: IW];
    assign rd_tag = rom_addr[ROM_AW-1 -: TW];

    // ------------------------------------------------------------------
    // Fill sequencer
    // ------------------------------------------------------------------
    logic               start;
    logic               busy;
    logic               wr0;
    logic               wr1;
    logic [LINE_AW-1:0] line;

    jt6295_romcache_fill u_fill (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (rom_addr[ROM_AW-1:2]),
        .mem_ok   (mem_ok),
        .mem_cs   (mem_cs),
        .mem_addr (mem_addr),
        .line     (line),
        .busy     (busy),
        .wr0      (wr0),
        .wr1      (wr1)
    );

    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;

    assign wr_idx = line[IW-1:0];
    assign wr_tag = line[LINE_AW-1 -: TW];

    // ------------------------------------------------------------------
    // Lookup
    // ------------------------------------------------------------------
    // settle marks the first idle cycle after a fill. The lookup is skipped
    // there so the new line is only ever read back through the hit path
    // from the following cycle on.
    logic settle;
    // fill_stale: a flush arrived while this fill was running, so its data
    // may belong to the old bank and the line must not become valid.
    logic fill_stale;
    logic ok_reg;
    logic [ROM_AW-1:0] ok_addr;

    logic lookup;
    logic hit;

    assign lookup = !busy && !settle;
    assign hit    = lookup && valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign start  = lookup && !hit;

    logic [31:0] rd_line;
    logic [15:0] rd_word;
    logic [7:0]  rd_byte;

    assign rd_line = data[rd_idx];
    assign rd_word = rd_off[1] ? rd_line[31:16] : rd_line[15:0];
    assign rd_byte = rd_off[0] ? rd_word[15:8]  : rd_word[7:0];

    // ------------------------------------------------------------------
    // Control state: valid bits, registered output byte and ok flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= '0;
            settle     <= 1'b0;
            fill_stale <= 1'b0;
            ok_reg     <= 1'b0;
            ok_addr    <= '0;
            rom_data   <= 8'd0;
        end else begin
            settle <= wr1;

            if (start)
                fill_stale <= 1'b0;
            else if (flush && busy)
                fill_stale <= 1'b1;

            // The victim line is invalidated as soon as its refill starts,
            // because word 0 overwrites its data before the fill completes.
            if (start)
                valid[rd_idx] <= 1'b0;
            if (wr1 && !flush && !fill_stale)
                valid[wr_idx] <= 1'b1;

            if (hit) begin
                rom_data <= rd_byte;
                ok_reg   <= 1'b1;
                ok_addr  <= rom_addr;
            end else if (start) begin
                ok_reg   <= 1'b0;
            end

            // Flush takes priority over a same-cycle hit or final beat.
            if (flush) begin
                valid  <= '0;
                ok_reg <= 1'b0;
            end
        end
    end

    // Tag and data arrays need no reset: they are qualified by valid.
    always_ff @(posedge clk) begin
        if (wr0)
            data[wr_idx][15:0] <= mem_data;
        if (wr1) begin
            data[wr_idx][31:16] <= mem_data;
            tags[wr_idx]        <= wr_tag;
        end
    end

    // A new address drops rom_ok in the same cycle, before the lookup result
    // for it has been registered.
    assign rom_ok = ok_reg && (rom_addr == ok_addr);

endmodule

// File: tb/tb_jt6295_romcache.sv
// Testbench for jt6295_romcache: directed scenarios plus a randomized run
// against a line-level cache model and a behavioural word memory.
module tb_jt6295_romcache;

    localparam int LINES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush;
    logic        flush_cmd = 1'b0;
    logic        flush_fin = 1'b0;
    logic [17:0] rom_addr = '0;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic        mem_cs;
    logic [16:0] mem_addr;
    logic [15:0] mem_data = '0;
    logic        mem_ok = 1'b0;

    int  lat = 1;              // memory wait: mem_ok on the lat-th request cycle
    bit  spur_en = 1'b0;       // inject mem_ok pulses while no request is pending
    bit  flush_at_final = 1'b0;// raise flush together with the second beat's mem_ok
    int  wcnt = 0;
    int  pas = 0;
    int  tot = 0;
    int  stale_cnt = 0;
    int  hs_err = 0;
    logic [16:0] req_q [$];    // word address of every completed beat

    assign flush = flush_cmd | flush_fin;

    always #5 clk = ~clk;

    jt6295_romcache #(.LINES(LINES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .mem_cs   (mem_cs),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_ok   (mem_ok)
    );

    // Behavioural sample memory contents.
    function automatic logic [15:0] mem_word(input logic [16:0] w);
        if (w == 17'h00080) return 16'h2211;
        if (w == 17'h00081) return 16'h4433;
        return (w[15:0] * 16'h9E37) ^ 16'hA55A;
    endfunction

    // Byte view of the same memory: even byte in the low half of each word.
    function automatic logic [7:0] rom_byte(input logic [17:0] a);
        logic [15:0] w;
        w = mem_word(a[17:1]);
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    // Memory responder, driven on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            wcnt = 0;
            mem_ok = 1'b0;
            flush_fin = 1'b0;
        end else if (mem_cs) begin
            wcnt++;
            if (wcnt >= lat) begin
                mem_ok = 1'b1;
                mem_data = mem_word(mem_addr);
                flush_fin = flush_at_final && mem_addr[0];
                wcnt = 0;
            end else begin
                mem_ok = 1'b0;
                flush_fin = 1'b0;
            end
        end else begin
            wcnt = 0;
            flush_fin = 1'b0;
            mem_ok = spur_en && ($urandom_range(0, 3) == 0);
            mem_data = 16'($urandom);
        end
    end

    // Request log and handshake rules: stable address while requesting,
    // request held until mem_ok, released the cycle after it.
    logic        prev_cs = 1'b0;
    logic        prev_ok = 1'b0;
    logic [16:0] prev_addr = '0;
    always @(posedge clk) begin
        if (rst_n && mem_cs && mem_ok) req_q.push_back(mem_addr);
        if (rst_n && prev_cs && mem_cs && (mem_addr !== prev_addr)) hs_err++;
        if (rst_n && prev_cs && !prev_ok && !mem_cs) hs_err++;
        if (rst_n && prev_cs && prev_ok && mem_cs) hs_err++;
        prev_cs   = mem_cs && rst_n;
        prev_ok   = mem_ok;
        prev_addr = mem_addr;
    end

    // rom_ok must never accompany a byte that is not the memory's byte.
    always @(negedge clk) begin
        if (rst_n && rom_ok && (rom_data !== rom_byte(rom_addr))) stale_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic wait_ok(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!rom_ok && cyc < limit);
    endtask

    task automatic test_reset();
        rom_addr = 18'h00102;
        lat = 1;
        #3 rst_n = 1'b0;
        #1;
        tot++; if (rom_data !== 8'h00) $display("FAIL reset_rom_data got %h want 00", rom_data); else pas++;
        tot++; if (rom_ok !== 1'b0) $display("FAIL reset_rom_ok got %b want 0", rom_ok); else pas++;
        tot++; if (mem_cs !== 1'b0) $display("FAIL reset_mem_cs got %b want 0", mem_cs); else pas++;
        tot++; if (mem_addr !== 17'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else pas++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_cold_miss();
        logic [5:0] cs_v, ok_v;
        int n0;
        n0 = req_q.size();
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            cs_v[k] = mem_cs;
            ok_v[k] = rom_ok;
        end
        tot++; if (cs_v !== 6'b000101) $display("FAIL cold_cs_pattern got %b want 000101", cs_v); else pas++;
        tot++; if (ok_v !== 6'b100000) $display("FAIL cold_ok_latency got %b want 100000", ok_v); else pas++;
        tot++; if (req_q.size() - n0 !== 2) $display("FAIL cold_beats got %0d want 2", req_q.size() - n0); else pas++;
        if (req_q.size() - n0 >= 2) begin
            tot++; if (req_q[n0] !== 17'h00080) $display("FAIL cold_req0 got %h want 00080", req_q[n0]); else pas++;
            tot++; if (req_q[n0+1] !== 17'h00081) $display("FAIL cold_req1 got %h want 00081", req_q[n0+1]); else pas++;
        end
        tot++; if (rom_data !== 8'h33) $display("FAIL cold_data got %h want 33", rom_data); else pas++;
    endtask

    task automatic test_seq_hits();
        logic [7:0] exp_b [4];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            rom_addr = 18'h00100 + 18'(i);
            @(posedge clk); #1;
            tot++; if (rom_data !== exp_b[i]) $display("FAIL seq_data[%0d] got %h want %h", i, rom_data, exp_b[i]); else pas++;
            tot++; if (rom_ok !== 1'b1) $display("FAIL seq_ok[%0d] got %b want 1", i, rom_ok); else pas++;
            tot++; if (mem_cs !== 1'b0) $display("FAIL seq_no_cs[%0d] got %b want 0", i, mem_cs); else pas++;
        end
    endtask

    task automatic test_conflict();
        logic [17:0] seq [3];
        int n0, cyc;
        seq = '{18'h00100, 18'h00110, 18'h00100};
        lat = 2;
        for (int i = 0; i < 3; i++) begin
            n0 = req_q.size();
            rom_addr = seq[i];
            if (i == 0) flush_cmd = 1'b1;   // start from an empty cache
            if (i == 0) begin @(posedge clk); #1; flush_cmd = 1'b0; end
            wait_ok(100, cyc);
            tot++; if (rom_ok !== 1'b1) $display("FAIL conflict_ok[%0d] got %b want 1", i, rom_ok); else pas++;
            tot++; if (req_q.size() - n0 !== 2) $display("FAIL conflict_beats[%0d] got %0d want 2", i, req_q.size() - n0); else pas++;
            if (req_q.size() > n0) begin
                tot++; if (req_q[n0] !== {seq[i][17:2], 1'b0})
                    $display("FAIL conflict_req[%0d] got %h want %h", i, req_q[n0], {seq[i][17:2], 1'b0}); else pas++;
            end
            tot++; if (rom_data !== rom_byte(seq[i])) $display("FAIL conflict_data[%0d] got %h want %h", i, rom_data, rom_byte(seq[i])); else pas++;
        end
    endtask

    task automatic test_midfill();
        logic [16:0] exp_r [4];
        int n0, cyc, k;
        exp_r = '{17'h01000, 17'h01001, 17'h01802, 17'h01803};
        lat = 5;
        n0 = req_q.size();
        rom_addr = 18'h02000;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!mem_cs && k < 20);
        tot++; if (mem_cs !== 1'b1) $display("FAIL midfill_req_start got %b want 1", mem_cs); else pas++;
        repeat (2) begin @(posedge clk); #1; end
        rom_addr = 18'h03004;
        wait_ok(200, cyc);
        tot++; if (rom_ok !== 1'b1) $display("FAIL midfill_ok got %b want 1", rom_ok); else pas++;
        tot++; if (req_q.size() - n0 !== 4) $display("FAIL midfill_beats got %0d want 4", req_q.size() - n0); else pas++;
        for (int i = 0; i < 4; i++) begin
            if (req_q.size() > n0 + i) begin
                tot++; if (req_q[n0+i] !== exp_r[i]) $display("FAIL midfill_req[%0d] got %h want %h", i, req_q[n0+i], exp_r[i]); else pas++;
            end
        end
        tot++; if (rom_data !== rom_byte(18'h03004)) $display("FAIL midfill_data got %h want %h", rom_data, rom_byte(18'h03004)); else pas++;
    endtask

    task automatic test_flush_final();
        int n0, cyc, k;
        lat = 1;
        n0 = req_q.size();
        flush_at_final = 1'b1;
        rom_addr = 18'h04008;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (req_q.size() < n0 + 2 && k < 50);
        flush_at_final = 1'b0;
        wait_ok(100, cyc);
        tot++; if (rom_ok !== 1'b1) $display("FAIL flush_ok got %b want 1", rom_ok); else pas++;
        tot++; if (req_q.size() - n0 !== 4) $display("FAIL flush_refill_beats got %0d want 4", req_q.size() - n0); else pas++;
        if (req_q.size() >= n0 + 3) begin
            tot++; if (req_q[n0+2] !== 17'h02004) $display("FAIL flush_refill_req got %h want 02004", req_q[n0+2]); else pas++;
        end
        tot++; if (rom_data !== rom_byte(18'h04008)) $display("FAIL flush_data got %h want %h", rom_data, rom_byte(18'h04008)); else pas++;
    endtask

    task automatic test_reset_req1();
        int n1, cyc, k;
        lat = 5;
        rom_addr = 18'h08010;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!(mem_cs && mem_addr[0]) && k < 50);
        tot++; if (mem_addr !== 17'h04009) $display("FAIL rst_reach_req1 got %h want 04009", mem_addr); else pas++;
        #2 rst_n = 1'b0;
        #1;
        tot++; if (mem_cs !== 1'b0) $display("FAIL rst_async_cs got %b want 0", mem_cs); else pas++;
        tot++; if (rom_ok !== 1'b0) $display("FAIL rst_async_ok got %b want 0", rom_ok); else pas++;
        repeat (2) @(posedge clk);
        #1;
        tot++; if (mem_cs !== 1'b0) $display("FAIL rst_hold_cs got %b want 0", mem_cs); else pas++;
        @(negedge clk) rst_n = 1'b1;
        n1 = req_q.size();
        wait_ok(200, cyc);
        tot++; if (rom_ok !== 1'b1) $display("FAIL rst_refill_ok got %b want 1", rom_ok); else pas++;
        tot++; if (req_q.size() - n1 !== 2) $display("FAIL rst_refill_beats got %0d want 2", req_q.size() - n1); else pas++;
        if (req_q.size() > n1) begin
            tot++; if (req_q[n1] !== 17'h04008) $display("FAIL rst_refill_req0 got %h want 04008", req_q[n1]); else pas++;
        end
        tot++; if (rom_data !== rom_byte(18'h08010)) $display("FAIL rst_refill_data got %h want %h", rom_data, rom_byte(18'h08010)); else pas++;
    endtask

    // Randomized accesses against a line-level model: a line is present if
    // the slot it maps to last received that line and no flush came since.
    task automatic test_random();
        logic [15:0] m_line [LINES];
        bit          m_vld  [LINES];
        logic [17:0] a;
        logic [15:0] ln;
        int n0, cyc, idx, exp_n, exp_cyc;
        bit fl, exp_hit;
        for (int j = 0; j < LINES; j++) begin m_vld[j] = 1'b0; m_line[j] = '0; end
        a = rom_addr;
        spur_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) a = a + 18'd1;
            else begin
                a = 18'($urandom_range(0, 255));
                if ($urandom_range(0, 1) != 0) a[14] = 1'b1;
            end
            lat = $urandom_range(1, 3);
            fl = (i == 0) || ($urandom_range(0, 7) == 0);
            if (fl) for (int j = 0; j < LINES; j++) m_vld[j] = 1'b0;
            ln = a[17:2];
            idx = int'(ln) % LINES;
            exp_hit = m_vld[idx] && (m_line[idx] == ln);
            exp_n = exp_hit ? 0 : 2;
            exp_cyc = exp_hit ? 1 : 4 + 2 * lat;
            m_vld[idx] = 1'b1;
            m_line[idx] = ln;
            n0 = req_q.size();
            rom_addr = a;
            if (fl) begin
                flush_cmd = 1'b1;
                @(posedge clk); #1;
                flush_cmd = 1'b0;
            end
            wait_ok(100, cyc);
            tot++; if (rom_ok !== 1'b1) $display("FAIL rnd_ok[%0d] addr %h got %b want 1", i, a, rom_ok); else pas++;
            tot++; if (req_q.size() - n0 !== exp_n) $display("FAIL rnd_beats[%0d] addr %h got %0d want %0d", i, a, req_q.size() - n0, exp_n); else pas++;
            tot++; if (rom_data !== rom_byte(a)) $display("FAIL rnd_data[%0d] addr %h got %h want %h", i, a, rom_data, rom_byte(a)); else pas++;
            if (!fl) begin
                tot++; if (cyc !== exp_cyc) $display("FAIL rnd_latency[%0d] addr %h got %0d want %0d", i, a, cyc, exp_cyc); else pas++;
            end
            if (!exp_hit && req_q.size() > n0) begin
                tot++; if (req_q[n0] !== {ln, 1'b0}) $display("FAIL rnd_req[%0d] got %h want %h", i, req_q[n0], {ln, 1'b0}); else pas++;
            end
        end
        spur_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_seq_hits();
        test_conflict();
        test_midfill();
        test_flush_final();
        test_reset_req1();
        test_random();
        repeat (2) @(posedge clk);
        tot++; if (stale_cnt !== 0) $display("FAIL stale_rom_ok got %0d events want 0", stale_cnt); else pas++;
        tot++; if (hs_err !== 0) $display("FAIL mem_handshake got %0d violations want 0", hs_err); else pas++;
        $display("%0d/%0d checks passed", pas, tot);
        $finish;
    end

endmodule
